// File: rtl/block_data_memory.sv
// block_data_memory
//   Block-organised main memory behind the direct-mapped data cache. It holds
//   64 blocks of 32 bits and serves one block read or block write at a time,
//   using a level request / busywait handshake with a fixed access latency.
//
// Ports
//   clock      rising-edge clock
//   reset      asynchronous, active-high; clears state and every block
//   read       block read request (level, held by the requester)
//   write      block write request (level, held by the requester)
//   address    6-bit block address {tag, index}
//   writedata  block to store, byte 0 in [7:0]
//   readdata   block returned by the last completed read
//   busywait   high while an access is pending or in progress
module block_data_memory #(
  parameter int LATENCY = 5
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        read,
  input  logic        write,
  input  logic [5:0]  address,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic        busywait
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  localparam logic [3:0] LOAD = 4'(LATENCY - 1);

  state_t      state_reg, state_next;
  logic [3:0]  count_reg, count_next;
  logic        req_read_reg, req_write_reg;
  logic [5:0]  addr_reg;
  logic [31:0] wdata_reg;
  logic [31:0] readdata_reg;
  logic [31:0] mem_reg [64];

  logic        accept;
  logic        complete;
  logic        op_write;
  logic [5:0]  op_addr;
  logic [31:0] op_wdata;

  // In IDLE the access being started comes straight from the inputs (this
  // matters only for LATENCY=1, which completes on the accept edge); after
  // that only the latched copy is used, so input changes while busy are
  // ignored. A simultaneous read+write is a write.
  assign op_write = (state_reg == IDLE) ? write     : req_write_reg;
  assign op_addr  = (state_reg == IDLE) ? address   : addr_reg;
  assign op_wdata = (state_reg == IDLE) ? writedata : wdata_reg;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_reg <= IDLE;
      count_reg <= 4'd0;
    end else begin
      state_reg <= state_next;
      count_reg <= count_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    count_next = count_reg;
    accept     = 1'b0;
    complete   = 1'b0;
    case (state_reg)
      IDLE: begin
        if (read || write) begin
          accept = 1'b1;
          if (LATENCY == 1) begin
            complete   = 1'b1;
            count_next = 4'd0;
            state_next = DONE;
          end else begin
            count_next = LOAD;
            state_next = BUSY;
          end
        end
      end
      BUSY: begin
        // The access completes on the edge that takes the counter to 0,
        // which places completion LATENCY-1 edges after the accept edge.
        count_next = count_reg - 4'd1;
        if (count_reg <= 4'd1) begin
          complete   = 1'b1;
          count_next = 4'd0;
          state_next = DONE;
        end
      end
      DONE: begin
        // A request still held unchanged is the one just serviced; only a
        // drop, a type change or an address change re-arms the memory.
        if (read != req_read_reg || write != req_write_reg || address != addr_reg)
          state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      req_read_reg  <= 1'b0;
      req_write_reg <= 1'b0;
      addr_reg      <= 6'd0;
      wdata_reg     <= 32'd0;
    end else if (accept) begin
      req_read_reg  <= read;
      req_write_reg <= write;
      addr_reg      <= address;
      wdata_reg     <= writedata;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      readdata_reg <= 32'd0;
    end else if (complete && !op_write) begin
      readdata_reg <= mem_reg[op_addr];
    end
  end

  // Storage needs a whole-array clear on reset, so it is held in flops.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 64; i++) mem_reg[i] <= 32'd0;
    end else if (complete && op_write) begin
      mem_reg[op_addr] <= op_wdata;
    end
  end

  assign readdata = readdata_reg;
  assign busywait = !reset && (((state_reg == IDLE) && (read || write)) || (state_reg == BUSY));

endmodule
